// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch/memory-stage request channels and RAM port of the memory arbiter
interface mem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              if_mc_en;
    logic [ADDR_W-1:0] if_mc_addr;
    logic [DATA_W-1:0] mc_if_data;
    logic              mc_if_valid;
    logic              mc_if_stall;
    logic              mem_mc_en;
    logic              mem_mc_rw;
    logic [ADDR_W-1:0] mem_mc_addr;
    logic [DATA_W-1:0] mem_mc_wdata;
    logic [DATA_W-1:0] mc_mem_data;
    logic              mc_mem_valid;
    logic              mc_ram_en;
    logic              mc_ram_we;
    logic [ADDR_W-1:0] mc_ram_addr;
    logic [DATA_W-1:0] mc_ram_wdata;
    logic [DATA_W-1:0] ram_mc_rdata;

    modport master (
        output if_mc_en, if_mc_addr, mem_mc_en, mem_mc_rw, mem_mc_addr, mem_mc_wdata, ram_mc_rdata,
        input  mc_if_data, mc_if_valid, mc_if_stall, mc_mem_data, mc_mem_valid,
               mc_ram_en, mc_ram_we, mc_ram_addr, mc_ram_wdata
    );

    modport slave (
        input  if_mc_en, if_mc_addr, mem_mc_en, mem_mc_rw, mem_mc_addr, mem_mc_wdata, ram_mc_rdata,
        output mc_if_data, mc_if_valid, mc_if_stall, mc_mem_data, mc_mem_valid,
               mc_ram_en, mc_ram_we, mc_ram_addr, mc_ram_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between fetch (IF) and memory stage (MEM).
// Fixed MEM-over-IF priority by default; define MC_FAIR_EN for round-robin arbitration.
module mem_arbiter #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int RAM_LATENCY = 1
) (
    input logic          clock,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_nx;
    logic [2:0] cnt;
    logic req, issue, done, pick_mem, gnt_mem, gnt_we;
    logic ram_en, ram_we, if_valid, mem_valid;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, if_data, mem_data;

    assign req   = bus.if_mc_en | bus.mem_mc_en;
    assign issue = state == IDLE && req;
    assign done  = state == BUSY && cnt == 3'd1;

`ifdef MC_FAIR_EN
    logic last_mem;
    // on a tie the side not served last wins; a lone requester always wins
    assign pick_mem = bus.mem_mc_en & (~bus.if_mc_en | ~last_mem);
    always_ff @(posedge clock)
        if (reset) last_mem <= 1'b0;
        else if (issue) last_mem <= pick_mem;
`else
    assign pick_mem = bus.mem_mc_en;
`endif

    always_ff @(posedge clock) state <= reset ? IDLE : state_nx;

    always_comb begin
        state_nx = state;
        if (issue) state_nx = BUSY;
        else if (done) state_nx = IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt       <= '0;
            gnt_mem   <= 1'b0;
            gnt_we    <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            if_data   <= '0;
            mem_data  <= '0;
            if_valid  <= 1'b0;
            mem_valid <= 1'b0;
        end else begin
            cnt       <= issue ? 3'(RAM_LATENCY) : state == BUSY ? cnt - 3'd1 : cnt;
            ram_en    <= issue;
            ram_we    <= issue & pick_mem & bus.mem_mc_rw;
            if_valid  <= done & ~gnt_mem;
            mem_valid <= done & gnt_mem;
            if (issue) begin
                gnt_mem   <= pick_mem;
                gnt_we    <= pick_mem & bus.mem_mc_rw;
                ram_addr  <= pick_mem ? bus.mem_mc_addr : bus.if_mc_addr;
                ram_wdata <= pick_mem ? bus.mem_mc_wdata : '0;
            end
            if (done && !gnt_mem) if_data <= bus.ram_mc_rdata;
            // a completed write leaves the MEM read data untouched
            if (done && gnt_mem && !gnt_we) mem_data <= bus.ram_mc_rdata;
        end
    end

    assign bus.mc_if_data   = if_data;
    assign bus.mc_if_valid  = if_valid;
    assign bus.mc_if_stall  = bus.if_mc_en & ~if_valid;
    assign bus.mc_mem_data  = mem_data;
    assign bus.mc_mem_valid = mem_valid;
    assign bus.mc_ram_en    = ram_en;
    assign bus.mc_ram_we    = ram_we;
    assign bus.mc_ram_addr  = ram_addr;
    assign bus.mc_ram_wdata = ram_wdata;
endmodule
